cp0_regfile: RTL and testbench
==============================

// Module: cp0_regfile
// PURPOSE
//  CP0 register-file responder for the CP0 read/write interface driven by the ALU (MFC0/MTC0).
//  Also services commit-side exception entry and ERET from the ROB, runs the Count/Compare timer,
//  and samples interrupts. Produces the redirect PC and the interrupt request seen by the ROB.
// PARAMETERS
//  PRID_VALUE  32'h0000_4220  read-only value of PRId (reg 15, sel 0)
//  EXC_VECTOR  32'hBFC0_0380  redirect target on exception entry
//  COUNT_DIV   2              clk cycles per Count increment (>=1)
// PORTS
//  clk           in   1   core clock
//  rst           in   1   reset, asynchronous, active-low
//  cp0_addr      in   5   CP0 register number
//  cp0_sel       in   3   CP0 select
//  cp0_wen       in   1   MTC0 write strobe (already gated by uop valid)
//  cp0_wdata     in   32  MTC0 write data
//  cp0_rdata     out  32  MFC0 read data, combinational from addr/sel
//  hw_int        in   6   external interrupt lines, level-sensitive
//  exc_valid     in   1   committing instruction takes exception/interrupt
//  exc_code      in   5   Cause.ExcCode to record
//  exc_pc        in   32  PC of excepting instruction
//  exc_bd        in   1   excepting instruction is in a delay slot
//  exc_badvaddr  in   32  faulting address (AdEL/AdES)
//  eret          in   1   committing ERET
//  int_req       out  1   interrupt pending, combinational
//  redirect_en   out  1   frontend redirect, registered pulse
//  redirect_pc   out  32  redirect target, registered
//  status_o      out  32  Status register value
//  epc_o         out  32  EPC register value
// BEHAVIOUR
//  Registers: BadVAddr(8,0) RO; Count(9,0) RW; Compare(11,0) RW; Status(12,0); Cause(13,0);
//   EPC(14,0) RW; PRId(15,0) RO=PRID_VALUE. Any other addr/sel reads 0; writes ignored.
//  Status: writable IM[15:8], EXL[1], IE[0]; BEV[22] reads 1; all other bits read 0.
//  Cause: BD[31], TI[30], IP[15:8], ExcCode[6:2]. Only IP[9:8] software-writable.
//   IP[15:10] <= hw_int each cycle (IP[15] = hw_int[5] | TI, see CONFIGURATION).
//  Reset (async, rst=0): Status=32'h0040_0000, Count/Compare/Cause/EPC/BadVAddr=0, prescaler=0,
//   redirect_en=0, redirect_pc=0. All outputs settle from these values.
//  Read: cp0_rdata shows the pre-edge value; a same-cycle write is visible next cycle.
//  Write: on posedge when cp0_wen; Count write also clears the prescaler; Compare write clears TI.
//  Count: prescaler counts 0..COUNT_DIV-1; at wrap Count <= Count+1 (wraps 2^32-1 -> 0).
//   TI sets on a tick where Count+1 == Compare; stays set until Compare is written.
//  int_req = Status.IE & ~Status.EXL & |(Status.IM & Cause.IP).
//  Exception entry (exc_valid): if EXL==0 { EPC <= exc_bd ? exc_pc-4 : exc_pc; Cause.BD <= exc_bd };
//   EXL <= 1; ExcCode <= exc_code; BadVAddr <= exc_badvaddr if exc_code is 4 or 5.
//   Next cycle: redirect_en=1 for one cycle, redirect_pc=EXC_VECTOR.
//  ERET (eret, no exc_valid): EXL <= 0; next cycle redirect_en=1, redirect_pc=EPC (pre-ERET value).
//  Priority, same cycle: exc_valid > eret > cp0_wen. A write coinciding with exc_valid or eret is
//   dropped (the writer is younger and flushed). A Compare write beats TI set in the same cycle.
//  Nested exception with EXL=1: EPC and BD are held; ExcCode/BadVAddr still update.
//  Reset asserted mid-operation: all state returns to reset values immediately; any pending
//   redirect is lost.
// CONFIGURATION
//  CP0_TIMER_INT_EN defined: TI is ORed into Cause.IP[15], and Compare writes clear TI.
//  Not defined: TI reads 0 and never sets; IP[15] = hw_int[5]. Count/Compare stay readable and
//   writable, and Count still increments.
// TESTING
//  Reset then read reg 12 -> 32'h0040_0000; read reg 15 -> PRID_VALUE; read reg 7 -> 0.
//  MTC0 Status=32'hFFFF_FFFF -> reads 32'h0040_FF03; MTC0 Cause=32'hFFFF_FFFF -> reads 32'h0000_0300.
//  Count=10, Compare=13, COUNT_DIV=2 -> TI=1 after 6 clocks; with IE=1, IM[7]=1, EXL=0 -> int_req=1;
//   write Compare -> TI=0 and int_req=0 next cycle.
//  exc_valid, code=4, pc=32'h8000_0104, bd=1, badvaddr=32'h1 -> EPC=32'h8000_0100, BD=1, BadVAddr=1,
//   EXL=1; next cycle redirect_en=1, redirect_pc=EXC_VECTOR; second exception keeps EPC.
//  eret with EPC=32'h8000_0200 -> EXL=0, redirect_pc=32'h8000_0200; eret+exc_valid same cycle ->
//   exception path only.
//  cp0_wen to EPC together with exc_valid -> write dropped; EPC = exception value.

Source files
------------

// File: rtl/cp0_regfile_if.sv
// ---------------------------------------------------------------------------
// cp0_regfile_if
//   Bus bundle between the core (ALU for MFC0/MTC0, ROB for commit events)
//   and the CP0 register file.
//
//   MFC0/MTC0 port : cp0_addr, cp0_sel, cp0_wen, cp0_wdata -> cp0_rdata
//   Commit port    : exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret
//   Results        : int_req (combinational), redirect_en / redirect_pc
//                    (registered one-cycle redirect to the frontend)
//
//   master modport : core side (drives requests, observes results)
//   slave  modport : CP0 side
// ---------------------------------------------------------------------------
interface cp0_regfile_if;
    logic [4:0]  cp0_addr;
    logic [2:0]  cp0_sel;
    logic        cp0_wen;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;

    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_pc;
    logic        exc_bd;
    logic [31:0] exc_badvaddr;
    logic        eret;

    logic        int_req;
    logic        redirect_en;
    logic [31:0] redirect_pc;

    modport master (
        output cp0_addr, cp0_sel, cp0_wen, cp0_wdata,
        output exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        input  cp0_rdata, int_req, redirect_en, redirect_pc
    );

    modport slave (
        input  cp0_addr, cp0_sel, cp0_wen, cp0_wdata,
        input  exc_valid, exc_code, exc_pc, exc_bd, exc_badvaddr, eret,
        output cp0_rdata, int_req, redirect_en, redirect_pc
    );
endinterface

// File: rtl/cp0_regfile.sv
// ---------------------------------------------------------------------------
// cp0_regfile
//   CP0 register file: BadVAddr, Count, Compare, Status, Cause, EPC, PRId.
//   Serves MFC0/MTC0, commit-side exception entry and ERET, the Count/Compare
//   timer and interrupt sampling. Produces the frontend redirect and the
//   interrupt request seen by the ROB.
//
//   Ports
//     clk        core clock
//     rst_n      asynchronous active-low reset
//     bus        cp0_regfile_if.slave (MFC0/MTC0, commit events, int_req,
//                redirect)
//     hw_int_i   external interrupt lines, level-sensitive, sampled each cycle
//     status_o   Status register value
//     epc_o      EPC register value
//
//   Optional feature macro: CP0_TIMER_INT_EN
//     defined   : Count==Compare timer interrupt (TI) sets and is ORed into
//                 Cause.IP[15]; a Compare write clears it.
//     undefined : TI reads 0 and never sets; Count/Compare still operate.
// ---------------------------------------------------------------------------
module cp0_regfile #(
    parameter logic [31:0] PRID_VALUE = 32'h0000_4220,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter int unsigned COUNT_DIV  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cp0_regfile_if.slave         bus,
    input  logic [5:0]           hw_int_i,
    output logic [31:0]          status_o,
    output logic [31:0]          epc_o
);
    localparam int unsigned PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;
    localparam logic [4:0] REG_PRID     = 5'd15;

    // State
    logic [PW-1:0] presc_q,    presc_d;
    logic [31:0]   count_q,    count_d;
    logic [31:0]   compare_q,  compare_d;
    logic [31:0]   epc_q,      epc_d;
    logic [31:0]   badvaddr_q, badvaddr_d;
    logic [7:0]    im_q,       im_d;
    logic          exl_q,      exl_d;
    logic          ie_q,       ie_d;
    logic          bd_q,       bd_d;
    logic          ti_q,       ti_d;
    logic [1:0]    ip_sw_q,    ip_sw_d;
    logic [5:0]    ip_hw_q,    ip_hw_d;
    logic [4:0]    exccode_q,  exccode_d;
    logic          redir_en_q, redir_en_d;
    logic [31:0]   redir_pc_q, redir_pc_d;

    // Derived views
    logic          tick;
    logic [31:0]   count_inc;
    logic [7:0]    ip;
    logic [31:0]   status_val;
    logic [31:0]   cause_val;
    logic [31:0]   rdata_c;
    logic          wr_hit;

    assign tick      = (presc_q == PW'(COUNT_DIV - 1));
    assign count_inc = count_q + 32'd1;

    // TI only reaches IP[15] when the timer interrupt is built in; otherwise
    // ti_q is held at 0 so the OR is harmless.
    assign ip = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};

    // BEV (bit 22) is hard-wired to 1.
    assign status_val = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
    assign cause_val  = {bd_q, ti_q, 14'd0, ip, 1'b0, exccode_q, 2'b00};

    assign status_o        = status_val;
    assign epc_o           = epc_q;
    assign bus.int_req     = ie_q & ~exl_q & (|(im_q & ip));
    assign bus.redirect_en = redir_en_q;
    assign bus.redirect_pc = redir_pc_q;

    // MFC0: pure function of pre-edge state, so a same-cycle MTC0 shows up
    // one cycle later.
    always_comb begin
        rdata_c = 32'd0;
        if (bus.cp0_sel == 3'd0) begin
            case (bus.cp0_addr)
                REG_BADVADDR: rdata_c = badvaddr_q;
                REG_COUNT:    rdata_c = count_q;
                REG_COMPARE:  rdata_c = compare_q;
                REG_STATUS:   rdata_c = status_val;
                REG_CAUSE:    rdata_c = cause_val;
                REG_EPC:      rdata_c = epc_q;
                REG_PRID:     rdata_c = PRID_VALUE;
                default:      rdata_c = 32'd0;
            endcase
        end
    end
    assign bus.cp0_rdata = rdata_c;

    // A write only lands when no commit event claims the cycle: the writer
    // is younger than the excepting/ERET instruction and gets flushed.
    assign wr_hit = bus.cp0_wen & ~bus.exc_valid & ~bus.eret & (bus.cp0_sel == 3'd0);

    always_comb begin
        presc_d    = presc_q;
        count_d    = count_q;
        compare_d  = compare_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        im_d       = im_q;
        exl_d      = exl_q;
        ie_d       = ie_q;
        bd_d       = bd_q;
        ti_d       = ti_q;
        ip_sw_d    = ip_sw_q;
        ip_hw_d    = hw_int_i;
        exccode_d  = exccode_q;
        redir_en_d = 1'b0;
        redir_pc_d = redir_pc_q;

        // Timer: prescaler wraps at COUNT_DIV-1, each wrap bumps Count.
        if (tick) begin
            presc_d = '0;
            count_d = count_inc;
        end else begin
            presc_d = presc_q + PW'(1);
        end

`ifdef CP0_TIMER_INT_EN
        if (tick && (count_inc == compare_q)) begin
            ti_d = 1'b1;
        end
`else
        ti_d = 1'b0;
`endif

        if (bus.exc_valid) begin
            // A nested exception (EXL already set) must not clobber the
            // original return address or its delay-slot flag.
            if (!exl_q) begin
                epc_d = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;
                bd_d  = bus.exc_bd;
            end
            exl_d     = 1'b1;
            exccode_d = bus.exc_code;
            if ((bus.exc_code == 5'd4) || (bus.exc_code == 5'd5)) begin
                badvaddr_d = bus.exc_badvaddr;
            end
            redir_en_d = 1'b1;
            redir_pc_d = EXC_VECTOR;
        end else if (bus.eret) begin
            exl_d      = 1'b0;
            redir_en_d = 1'b1;
            redir_pc_d = epc_q;
        end else if (wr_hit) begin
            case (bus.cp0_addr)
                REG_COUNT: begin
                    count_d = bus.cp0_wdata;
                    presc_d = '0;
                end
                REG_COMPARE: begin
                    // Overrides a TI set computed above in the same cycle.
                    compare_d = bus.cp0_wdata;
                    ti_d      = 1'b0;
                end
                REG_STATUS: begin
                    im_d  = bus.cp0_wdata[15:8];
                    exl_d = bus.cp0_wdata[1];
                    ie_d  = bus.cp0_wdata[0];
                end
                REG_CAUSE: begin
                    ip_sw_d = bus.cp0_wdata[9:8];
                end
                REG_EPC: begin
                    epc_d = bus.cp0_wdata;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            count_q    <= 32'd0;
            compare_q  <= 32'd0;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            im_q       <= 8'd0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ti_q       <= 1'b0;
            ip_sw_q    <= 2'd0;
            ip_hw_q    <= 6'd0;
            exccode_q  <= 5'd0;
            redir_en_q <= 1'b0;
            redir_pc_q <= 32'd0;
        end else begin
            presc_q    <= presc_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            im_q       <= im_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            bd_q       <= bd_d;
            ti_q       <= ti_d;
            ip_sw_q    <= ip_sw_d;
            ip_hw_q    <= ip_hw_d;
            exccode_q  <= exccode_d;
            redir_en_q <= redir_en_d;
            redir_pc_q <= redir_pc_d;
        end
    end
endmodule

// File: tb/tb_cp0_regfile.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_cp0_regfile
//   Directed bench for cp0_regfile with default parameters
//   (PRId 32'h0000_4220, vector 32'hBFC0_0380, COUNT_DIV 2).
// ---------------------------------------------------------------------------
module tb_cp0_regfile;
    logic        clk;
    logic        rst_n;
    logic [5:0]  hw_int;
    logic [31:0] status_w;
    logic [31:0] epc_w;

    int checks;
    int failures;
    logic done;

    cp0_regfile_if bus();

    cp0_regfile dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .hw_int_i (hw_int),
        .status_o (status_w),
        .epc_o    (epc_w)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        $display("check %-14s observed=%08h expected=%08h", tag, obs, exp);
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and land 1 ns after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [31:0] data);
        bus.cp0_addr  = addr;
        bus.cp0_sel   = 3'd0;
        bus.cp0_wdata = data;
        bus.cp0_wen   = 1'b1;
        tick(1);
        bus.cp0_wen   = 1'b0;
    endtask

    task automatic rd(input logic [4:0] addr, output logic [31:0] data);
        bus.cp0_addr = addr;
        bus.cp0_sel  = 3'd0;
        #1;
        data = bus.cp0_rdata;
    endtask

    logic [31:0] v;
    logic        exp_ti;

    initial begin
        done = 1'b0;
        #200000;
        if (!done) begin
            failures++;
            $error("FAIL timeout: stimulus did not complete within wait limit");
            $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
            $finish;
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
`ifdef CP0_TIMER_INT_EN
        exp_ti = 1'b1;
`else
        exp_ti = 1'b0;
`endif
        rst_n            = 1'b0;
        hw_int           = 6'd0;
        bus.cp0_addr     = 5'd0;
        bus.cp0_sel      = 3'd0;
        bus.cp0_wen      = 1'b0;
        bus.cp0_wdata    = 32'd0;
        bus.exc_valid    = 1'b0;
        bus.exc_code     = 5'd0;
        bus.exc_pc       = 32'd0;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'd0;
        bus.eret         = 1'b0;
        tick(2);
        rst_n = 1'b1;

        // Reset state
        rd(5'd12, v);  chk("rst_status", v, 32'h0040_0000);
        rd(5'd15, v);  chk("rst_prid", v, 32'h0000_4220);
        rd(5'd7, v);   chk("rst_unmapped", v, 32'h0);
        chk("rst_redir_en", bus.redirect_en, 32'h0);
        chk("rst_redir_pc", bus.redirect_pc, 32'h0);
        chk("rst_epc_o", epc_w, 32'h0);

        // Status/Cause write masks
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, v);  chk("status_mask", v, 32'h0040_FF03);
        chk("status_o", status_w, 32'h0040_FF03);
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, v);  chk("cause_mask", v, 32'h0000_0300);
        chk("intreq_exl", bus.int_req, 32'h0);
        mtc0(5'd12, 32'h0000_FF01);
        chk("intreq_sw", bus.int_req, 32'h1);
        mtc0(5'd13, 32'h0);
        chk("intreq_swclr", bus.int_req, 32'h0);

        // Count/Compare timer
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd11, 32'd13);
        mtc0(5'd9, 32'd10);
        tick(5);
        rd(5'd9, v);   chk("count_5clk", v, 32'd12);
        rd(5'd13, v);  chk("ti_early", v, 32'h0);
        tick(1);
        rd(5'd9, v);   chk("count_6clk", v, 32'd13);
        rd(5'd13, v);  chk("ti_set", v, exp_ti ? 32'h4000_8000 : 32'h0);
        chk("intreq_ti", bus.int_req, {31'd0, exp_ti});
        mtc0(5'd11, 32'd100);
        rd(5'd13, v);  chk("ti_clear", v, 32'h0);
        chk("intreq_ticlr", bus.int_req, 32'h0);

        // Hardware interrupt sampling
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b000001;
        tick(1);
        rd(5'd13, v);  chk("hw_ip", v, 32'h0000_0400);
        chk("intreq_hw", bus.int_req, 32'h1);
        hw_int = 6'd0;
        tick(1);
        chk("intreq_hwclr", bus.int_req, 32'h0);

        // Exception entry in a delay slot, with a coinciding EPC write
        mtc0(5'd12, 32'h0000_0001);
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd4;
        bus.exc_pc       = 32'h8000_0104;
        bus.exc_bd       = 1'b1;
        bus.exc_badvaddr = 32'h1;
        bus.cp0_addr     = 5'd14;
        bus.cp0_wdata    = 32'hDEAD_BEEF;
        bus.cp0_wen      = 1'b1;
        tick(1);
        bus.exc_valid    = 1'b0;
        bus.cp0_wen      = 1'b0;
        chk("exc_redir_en", bus.redirect_en, 32'h1);
        chk("exc_redir_pc", bus.redirect_pc, 32'hBFC0_0380);
        rd(5'd14, v);  chk("exc_epc", v, 32'h8000_0100);
        rd(5'd13, v);  chk("exc_cause", v, 32'h8000_0010);
        rd(5'd8, v);   chk("exc_badva", v, 32'h1);
        chk("exc_status", status_w, 32'h0040_0003);
        tick(1);
        chk("exc_redir_off", bus.redirect_en, 32'h0);

        // Nested exception: EPC/BD held, ExcCode/BadVAddr update
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd5;
        bus.exc_pc       = 32'h8000_0500;
        bus.exc_bd       = 1'b0;
        bus.exc_badvaddr = 32'h0000_1234;
        tick(1);
        bus.exc_valid    = 1'b0;
        chk("nest_epc", epc_w, 32'h8000_0100);
        rd(5'd13, v);  chk("nest_cause", v, 32'h8000_0014);
        rd(5'd8, v);   chk("nest_badva", v, 32'h0000_1234);
        chk("nest_redir", bus.redirect_en, 32'h1);

        // Non-address exception leaves BadVAddr alone
        bus.exc_valid    = 1'b1;
        bus.exc_code     = 5'd8;
        bus.exc_badvaddr = 32'h0000_FFFF;
        tick(1);
        bus.exc_valid    = 1'b0;
        rd(5'd8, v);   chk("sys_badva", v, 32'h0000_1234);
        rd(5'd13, v);  chk("sys_cause", v, 32'h8000_0020);

        // ERET
        mtc0(5'd14, 32'h8000_0200);
        bus.eret = 1'b1;
        tick(1);
        bus.eret = 1'b0;
        chk("eret_redir_en", bus.redirect_en, 32'h1);
        chk("eret_redir_pc", bus.redirect_pc, 32'h8000_0200);
        chk("eret_status", status_w, 32'h0040_0001);
        tick(1);
        chk("eret_redir_off", bus.redirect_en, 32'h0);

        // ERET together with an exception: exception wins
        bus.exc_valid    = 1'b1;
        bus.eret         = 1'b1;
        bus.exc_code     = 5'd0;
        bus.exc_pc       = 32'h8000_0300;
        bus.exc_bd       = 1'b0;
        tick(1);
        bus.exc_valid    = 1'b0;
        bus.eret         = 1'b0;
        chk("both_epc", epc_w, 32'h8000_0300);
        chk("both_redir_pc", bus.redirect_pc, 32'hBFC0_0380);
        chk("both_status", status_w, 32'h0040_0003);

        // Reset mid-operation drops a pending redirect
        bus.eret = 1'b1;
        tick(1);
        bus.eret = 1'b0;
        chk("pre_rst_redir", bus.redirect_en, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_redir", bus.redirect_en, 32'h0);
        chk("mid_rst_pc", bus.redirect_pc, 32'h0);
        chk("mid_rst_status", status_w, 32'h0040_0000);
        chk("mid_rst_epc", epc_w, 32'h0);
        tick(1);
        rst_n = 1'b1;

        done = 1'b1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
